// File: rtl/tia_playfield_serializer.sv
// tia_playfield_serializer: serialises a PF_BITS playfield pattern across two half-lines, right half repeated or reflected.
// Define TIA_PF_SCORE_EN to add o_pf_score_right (pixel set during the right half, for score-mode colouring).
module tia_playfield_serializer #(
  parameter int PF_BITS      = 20,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               i_clkp,
  input  logic               i_reset,
  input  logic               i_line_start,
  input  logic               i_pf_we,
  input  logic [PF_BITS-1:0] i_pf_data,
  input  logic               i_ref,
  output logic               o_pf,
  output logic               o_pf_center,
  output logic               o_pf_active
`ifdef TIA_PF_SCORE_EN
  ,
  output logic               o_pf_score_right
`endif
);
  localparam int SW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(PF_BITS);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  generate
    if (PF_BITS < 2 || PF_BITS > 32 || CLKS_PER_BIT < 1 || CLKS_PER_BIT > 16) begin : g_bad_params
      $error("tia_playfield_serializer: PF_BITS must be 2..32 and CLKS_PER_BIT 1..16");
    end
  endgenerate
  state_t             r_state;
  logic [PF_BITS-1:0] r_pat;
  logic [SW-1:0]      r_sub;
  logic [BW-1:0]      r_bit;
  logic               r_ref_l;
  logic               w_sub_wrap;
  logic               w_bit_last;
  logic               w_pix;
  logic [BW-1:0]      w_idx;
  always_comb begin
    w_sub_wrap = r_sub == SW'(CLKS_PER_BIT - 1);
    w_bit_last = r_bit == BW'(PF_BITS - 1);
    w_idx      = (r_state == RIGHT && r_ref_l) ? BW'(PF_BITS - 1) - r_bit : r_bit;
    w_pix      = r_state != IDLE && r_pat[w_idx];
  end
  // The pattern register feeds the pixel mux directly, so a write shows on the very next pixel.
  always_ff @(posedge i_clkp) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_sub       <= '0;
      r_bit       <= '0;
      r_ref_l     <= 1'b0;
      o_pf        <= 1'b0;
      o_pf_center <= 1'b0;
      o_pf_active <= 1'b0;
`ifdef TIA_PF_SCORE_EN
      o_pf_score_right <= 1'b0;
`endif
    end else begin
      o_pf        <= w_pix;
      o_pf_center <= r_state == RIGHT && r_bit == '0 && r_sub == '0;
      o_pf_active <= r_state != IDLE;
`ifdef TIA_PF_SCORE_EN
      o_pf_score_right <= r_state == RIGHT && w_pix;
`endif
      if (i_pf_we)
        r_pat <= i_pf_data;
      if (i_line_start) begin
        r_state <= LEFT;
        r_sub   <= '0;
        r_bit   <= '0;
      end else if (r_state != IDLE) begin
        r_sub <= w_sub_wrap ? '0 : r_sub + 1'b1;
        if (w_sub_wrap) begin
          r_bit <= w_bit_last ? '0 : r_bit + 1'b1;
          if (w_bit_last) begin
            r_state <= r_state == LEFT ? RIGHT : IDLE;
            if (r_state == LEFT)
              r_ref_l <= i_ref;
          end
        end
      end
    end
  end
endmodule
